// File: rtl/video_pll_pkg.sv
// Shared constants and helpers for the video PLL core.
package video_pll_pkg;

  localparam int ODIV_MAX            = 128;
  localparam int LOCK_CYCLES_DEFAULT = 1024;

  // A counter that must hold values 0..n-1 needs at least one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/video_pll_div.sv
// Integer clock divider: high for ceil(N/2) input cycles, low for floor(N/2).
// N=1 passes the input clock through. Honours VIDEO_PLL_OUT_GATE_EN via its en input.
module video_pll_div
  import video_pll_pkg::*;
#(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic clk_o
);

  if (N < 1 || N > ODIV_MAX) begin : g_bad_n
    $fatal(1, "video_pll_div: divide ratio %0d outside 1..%0d", N, ODIV_MAX);
  end

  if (N == 1) begin : g_pass
    logic en_n;

    // Enable is retimed on the falling edge so the passthrough never chops a high phase.
    always_ff @(negedge clk or posedge rst) begin
      if (rst) en_n <= 1'b0;
      else     en_n <= en;
    end

    assign clk_o = clk & en_n;
  end else begin : g_div
    localparam int W = cnt_width(N);
    localparam logic [W-1:0] LAST = W'(N - 1);
    localparam logic [W-1:0] HIGH = W'((N + 1) / 2);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt   <= '0;
        clk_o <= 1'b0;
      end else if (en) begin
        clk_o <= (cnt < HIGH);
        cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/video_pll_core.sv
// Digital stand-in for a video PLL: lock timer plus two integer dividers on clkin1.
// Define VIDEO_PLL_OUT_GATE_EN to hold both outputs low until lock.
module video_pll_core
  import video_pll_pkg::*;
#(
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEFAULT,
  parameter int ODIV0       = 2,
  parameter int ODIV1       = 4
) (
  input  logic clkin1,
  input  logic pll_rst,
  output logic clkout0,
  output logic clkout1,
  output logic pll_lock
);

  localparam int LW = cnt_width(LOCK_CYCLES + 1);
  localparam logic [LW-1:0] LOCK_VAL = LW'(LOCK_CYCLES);

  if (LOCK_CYCLES < 1) begin : g_bad_lock
    $fatal(1, "video_pll_core: LOCK_CYCLES must be at least 1");
  end

  logic [1:0]    sync;
  logic          run;
  logic [LW-1:0] lock_cnt;
  logic          lock_d;
  logic          div_en;

  // Two-stage release synchronizer; everything downstream waits for run.
  always_ff @(posedge clkin1 or posedge pll_rst) begin
    if (pll_rst) sync <= '0;
    else         sync <= {sync[0], 1'b1};
  end

  assign run    = sync[1];
  assign lock_d = pll_lock | (run && (lock_cnt == LOCK_VAL - 1'b1));

  always_ff @(posedge clkin1 or posedge pll_rst) begin
    if (pll_rst) begin
      lock_cnt <= '0;
      pll_lock <= 1'b0;
    end else begin
      if (run && (lock_cnt != LOCK_VAL)) lock_cnt <= lock_cnt + 1'b1;
      pll_lock <= lock_d;
    end
  end

`ifdef VIDEO_PLL_OUT_GATE_EN
  assign div_en = lock_d;
`else
  assign div_en = run;
`endif

  video_pll_div #(.N(ODIV0)) u_div0 (
    .clk   (clkin1),
    .rst   (pll_rst),
    .en    (div_en),
    .clk_o (clkout0)
  );

  video_pll_div #(.N(ODIV1)) u_div1 (
    .clk   (clkin1),
    .rst   (pll_rst),
    .en    (div_en),
    .clk_o (clkout1)
  );

endmodule

// File: tb/tb_video_pll_core.sv
// Directed bench for video_pll_core: default instance plus a LOCK=16, ODIV0=3, ODIV1=1 instance.
module tb_video_pll_core;

  logic clk = 1'b0;
  logic pll_rst = 1'b1;
  logic clkout0_a, clkout1_a, pll_lock_a;
  logic clkout0_b, clkout1_b, pll_lock_b;

  int n_vec  = 0;
  int n_fail = 0;
  int cur_edge = 0;
  int lock_rises = 0;

  always #10 clk = ~clk;

  video_pll_core u_dut_a (
    .clkin1   (clk),
    .pll_rst  (pll_rst),
    .clkout0  (clkout0_a),
    .clkout1  (clkout1_a),
    .pll_lock (pll_lock_a)
  );

  video_pll_core #(.LOCK_CYCLES(16), .ODIV0(3), .ODIV1(1)) u_dut_b (
    .clkin1   (clk),
    .pll_rst  (pll_rst),
    .clkout0  (clkout0_b),
    .clkout1  (clkout1_b),
    .pll_lock (pll_lock_b)
  );

  always @(posedge pll_lock_a) lock_rises++;

  typedef struct {
    int   k;
    logic la, c0a, c1a, lb, c0b, c1b;
  } vec_t;

  vec_t tbl[$];

  task automatic check_output(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_low(input string tag);
    check_output({tag, " lock_a"}, int'(pll_lock_a), 0);
    check_output({tag, " clkout0_a"}, int'(clkout0_a), 0);
    check_output({tag, " clkout1_a"}, int'(clkout1_a), 0);
    check_output({tag, " lock_b"}, int'(pll_lock_b), 0);
    check_output({tag, " clkout0_b"}, int'(clkout0_b), 0);
    check_output({tag, " clkout1_b"}, int'(clkout1_b), 0);
  endtask

  // Releases reset mid-cycle; edge 1 is the next rising edge.
  task automatic apply_stimulus();
    @(negedge clk);
    pll_rst  = 1'b0;
    cur_edge = 0;
  endtask

  task automatic step_to(input int k);
    repeat (k - cur_edge) @(posedge clk);
    #1;
    cur_edge = k;
  endtask

  task automatic wait_lock(output int edges);
    edges = 0;
    while (!pll_lock_a && edges < 1200) begin
      @(posedge clk);
      #1;
      edges++;
    end
    cur_edge = edges;
  endtask

  task automatic assert_reset();
    @(posedge clk);
    #5;
    pll_rst = 1'b1;
    #1;
  endtask

  initial begin
    int edges;
    int hi0a, hi1a, hi0b, hi1b, misalign;
    logic p0a, p1a;

`ifdef VIDEO_PLL_OUT_GATE_EN
    tbl.push_back(vec_t'{1,    0, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{17,   0, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{18,   0, 0, 0, 1, 1, 1});
    tbl.push_back(vec_t'{19,   0, 0, 0, 1, 1, 1});
    tbl.push_back(vec_t'{20,   0, 0, 0, 1, 0, 1});
    tbl.push_back(vec_t'{1025, 0, 0, 0, 1, 0, 1});
    tbl.push_back(vec_t'{1026, 1, 1, 1, 1, 1, 1});
    tbl.push_back(vec_t'{1027, 1, 0, 1, 1, 1, 1});
`else
    tbl.push_back(vec_t'{1,    0, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{2,    0, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{3,    0, 1, 1, 0, 1, 1});
    tbl.push_back(vec_t'{4,    0, 0, 1, 0, 1, 1});
    tbl.push_back(vec_t'{5,    0, 1, 0, 0, 0, 1});
    tbl.push_back(vec_t'{6,    0, 0, 0, 0, 1, 1});
    tbl.push_back(vec_t'{7,    0, 1, 1, 0, 1, 1});
    tbl.push_back(vec_t'{17,   0, 1, 0, 0, 0, 1});
    tbl.push_back(vec_t'{18,   0, 0, 0, 1, 1, 1});
    tbl.push_back(vec_t'{1025, 0, 1, 0, 1, 0, 1});
    tbl.push_back(vec_t'{1026, 1, 0, 0, 1, 1, 1});
    tbl.push_back(vec_t'{1027, 1, 1, 1, 1, 1, 1});
`endif

    // Reset held, sampled while clkin1 is high so the passthrough is exercised.
    #35;
    check_all_low("in reset");
    apply_stimulus();

    foreach (tbl[i]) begin
      step_to(tbl[i].k);
      check_output($sformatf("e%0d lock_a", tbl[i].k), int'(pll_lock_a), int'(tbl[i].la));
      check_output($sformatf("e%0d clkout0_a", tbl[i].k), int'(clkout0_a), int'(tbl[i].c0a));
      check_output($sformatf("e%0d clkout1_a", tbl[i].k), int'(clkout1_a), int'(tbl[i].c1a));
      check_output($sformatf("e%0d lock_b", tbl[i].k), int'(pll_lock_b), int'(tbl[i].lb));
      check_output($sformatf("e%0d clkout0_b", tbl[i].k), int'(clkout0_b), int'(tbl[i].c0b));
      check_output($sformatf("e%0d clkout1_b", tbl[i].k), int'(clkout1_b), int'(tbl[i].c1b));
    end

    // Duty and alignment over 12 locked cycles.
    hi0a = 0; hi1a = 0; hi0b = 0; hi1b = 0; misalign = 0;
    p0a = clkout0_a;
    p1a = clkout1_a;
    for (int i = 0; i < 12; i++) begin
      step_to(cur_edge + 1);
      hi0a += int'(clkout0_a);
      hi1a += int'(clkout1_a);
      hi0b += int'(clkout0_b);
      hi1b += int'(clkout1_b);
      if (clkout1_a && !p1a && !(clkout0_a && !p0a)) misalign++;
      p0a = clkout0_a;
      p1a = clkout1_a;
    end
    check_output("duty clkout0_a highs", hi0a, 6);
    check_output("duty clkout1_a highs", hi1a, 6);
    check_output("duty clkout0_b highs", hi0b, 8);
    check_output("passthrough clkout1_b highs", hi1b, 12);
    check_output("rising edge misalign", misalign, 0);

    // Reset while locked: everything drops at once, then a full relock.
    assert_reset();
    check_all_low("async reset locked");
    repeat (2) @(posedge clk);
    #1;
    check_output("held reset lock_a", int'(pll_lock_a), 0);
    apply_stimulus();
    wait_lock(edges);
    check_output("relock edges", edges, 1026);
    check_output("relock lock_b", int'(pll_lock_b), 1);

    // Reset when the lock counter is at 500: no lock pulse, full count after release.
    assert_reset();
    apply_stimulus();
    step_to(502);
    check_output("count500 lock_a", int'(pll_lock_a), 0);
    assert_reset();
    check_output("abort lock_a", int'(pll_lock_a), 0);
    check_output("abort clkout0_a", int'(clkout0_a), 0);
    apply_stimulus();
    wait_lock(edges);
    check_output("lock after abort edges", edges, 1026);
    step_to(cur_edge + 50);
    check_output("lock_a stays high", int'(pll_lock_a), 1);
    check_output("lock rising edges", lock_rises, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
